// File: rtl/sha256_pkg.sv
// sha256_pkg: register map, CTRL/STATUS bit positions and master FSM states shared by the
// sha256 slave and its bus master.
package sha256_pkg;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_BLOCK0  = 8'h10;
  localparam logic [7:0] ADDR_DIGEST0 = 8'h20;
  localparam int CTRL_INIT    = 0;
  localparam int CTRL_NEXT    = 1;
  localparam int CTRL_MODE    = 2;
  localparam int STATUS_READY = 0;
  localparam int STATUS_VALID = 1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BLOCK,
    S_WR_CTRL,
    S_HOLDOFF,
    S_POLL,
    S_RD_DIGEST,
    S_DONE
  } state_e;
endpackage

// File: rtl/sha256_bus_master_if.sv
// sha256_bus_master_if: sha256 slave register bus.
//   cs, we, address, write_data : master -> slave
//   read_data                   : slave -> master, combinational from cs/address
interface sha256_bus_master_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master (output cs, we, address, write_data, input read_data);
  modport slave  (input cs, we, address, write_data, output read_data);
endinterface

// File: rtl/sha256_bus_master.sv
// sha256_bus_master: hashes one 512-bit block per request through the sha256 slave registers.
//   clk, reset_n (async, active-low)
//   start_i, init_mode_i, sha_mode_i, block_in_i : request, accepted only while ready_o=1
//   ready_o, digest_out_o, digest_valid_o, error_o : result handshake, error is a sticky timeout
//   bus : register bus master (block writes, CTRL write, STATUS poll, digest reads)
module sha256_bus_master
  import sha256_pkg::*;
#(
  parameter int HOLDOFF = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       init_mode_i,
  input  logic                       sha_mode_i,
  input  logic [511:0]               block_in_i,
  output logic                       ready_o,
  output logic [255:0]               digest_out_o,
  output logic                       digest_valid_o,
  output logic                       error_o,
  sha256_bus_master_if.master        bus
);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [PW-1:0] POLL_MAX  = PW'(TIMEOUT);
  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [511:0]   blk_q, blk_d;
  logic [223:0]   shadow_q, shadow_d;
  logic [255:0]   digest_q, digest_d;
  logic           init_q, init_d, mode_q, mode_d, err_q, err_d;
  logic           ready_q, ready_d, dv_q, dv_d, cs_q, cs_d, we_q, we_d;
  logic [7:0]     addr_q, addr_d;
  logic [31:0]    wd_q, wd_d, ctrl;
  logic           status_ok;
  always_comb begin
    ctrl = '0;
    ctrl[CTRL_INIT] = init_q;
    ctrl[CTRL_NEXT] = ~init_q;
    ctrl[CTRL_MODE] = mode_q;
    status_ok = bus.read_data[STATUS_READY] & bus.read_data[STATUS_VALID];
    state_d  = state_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    poll_d   = poll_q;
    blk_d    = blk_q;
    shadow_d = shadow_q;
    digest_d = digest_q;
    init_d   = init_q;
    mode_d   = mode_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_WR_BLOCK;
        idx_d   = '0;
        blk_d   = block_in_i;
        init_d  = init_mode_i;
        mode_d  = sha_mode_i;
        err_d   = 1'b0;
      end
      // the block is rotated so the word for the next write is always at the top
      S_WR_BLOCK: begin
        idx_d   = idx_q + 4'd1;
        blk_d   = {blk_q[479:0], blk_q[511:480]};
        state_d = idx_q == 4'd15 ? S_WR_CTRL : S_WR_BLOCK;
      end
      S_WR_CTRL: begin
        state_d = S_HOLDOFF;
        hold_d  = HOLD_LAST;
      end
      S_HOLDOFF: begin
        hold_d  = hold_q - HW'(1);
        state_d = hold_q == '0 ? S_POLL : S_HOLDOFF;
        poll_d  = '0;
      end
      S_POLL: begin
        poll_d = poll_q == POLL_MAX ? poll_q : poll_q + PW'(1);
        if (status_ok) begin
          state_d = S_RD_DIGEST;
          idx_d   = '0;
        end else if (poll_d == POLL_MAX) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      // digest words arrive in order, so a shift register lands word 0 at the top
      S_RD_DIGEST: begin
        idx_d    = idx_q + 4'd1;
        shadow_d = {shadow_q[191:0], bus.read_data};
        if (idx_q == 4'd7) begin
          state_d  = S_DONE;
          digest_d = {shadow_q, bus.read_data};
        end
      end
      default: state_d = S_IDLE;
    endcase
    // registered outputs describe the cycle the FSM is about to enter
    cs_d    = state_d inside {S_WR_BLOCK, S_WR_CTRL, S_POLL, S_RD_DIGEST};
    we_d    = state_d inside {S_WR_BLOCK, S_WR_CTRL};
    addr_d  = state_d == S_WR_BLOCK  ? ADDR_BLOCK0 + {4'h0, idx_d} :
              state_d == S_WR_CTRL   ? ADDR_CTRL :
              state_d == S_POLL      ? ADDR_STATUS :
              state_d == S_RD_DIGEST ? ADDR_DIGEST0 + {4'h0, idx_d} : 8'h00;
    wd_d    = state_d == S_WR_BLOCK ? blk_d[511:480] :
              state_d == S_WR_CTRL  ? ctrl : 32'h0;
    ready_d = state_d == S_IDLE;
    dv_d    = state_d == S_DONE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      poll_q   <= '0;
      blk_q    <= '0;
      shadow_q <= '0;
      digest_q <= '0;
      init_q   <= 1'b0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      dv_q     <= 1'b0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      poll_q   <= poll_d;
      blk_q    <= blk_d;
      shadow_q <= shadow_d;
      digest_q <= digest_d;
      init_q   <= init_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      dv_q     <= dv_d;
      cs_q     <= cs_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
    end
  assign bus.cs         = cs_q;
  assign bus.we         = we_q;
  assign bus.address    = addr_q;
  assign bus.write_data = wd_q;
  assign ready_o        = ready_q;
  assign digest_out_o   = digest_q;
  assign digest_valid_o = dv_q;
  assign error_o        = err_q;
endmodule

// File: tb/tb_sha256_bus_master.sv
// tb_sha256_bus_master: bus master against a behavioural sha256 slave and a silent stub slave
module tb_sha256_bus_master;
  import sha256_pkg::*;
  localparam logic [2047:0] K_ALL = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [511:0] ABC    = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [223:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
  logic clk = 1'b0, reset_n = 1'b0;
  logic start, start_to, init_mode, sha_mode;
  logic [511:0] block_in;
  logic ready, dv, err, ready_t, dv_t, err_t;
  logic [255:0] digest, digest_t;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  sha256_bus_master_if bus();
  sha256_bus_master_if bus_to();
  sha256_bus_master #(.HOLDOFF(4), .TIMEOUT(1024)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .init_mode_i(init_mode), .sha_mode_i(sha_mode),
    .block_in_i(block_in), .ready_o(ready), .digest_out_o(digest), .digest_valid_o(dv), .error_o(err), .bus(bus));
  sha256_bus_master #(.HOLDOFF(4), .TIMEOUT(16)) dut_to (
    .clk(clk), .reset_n(reset_n), .start_i(start_to), .init_mode_i(init_mode), .sha_mode_i(sha_mode),
    .block_in_i(block_in), .ready_o(ready_t), .digest_out_o(digest_t), .digest_valid_o(dv_t), .error_o(err_t), .bus(bus_to));
  assign bus_to.read_data = 32'h0;
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [255:0] h0(input logic sm);
    return sm ? 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
              : 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  endfunction
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_ALL[2047-32*t -: 32] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction
  // behavioural slave: ready lags the CTRL write by two cycles, then busy for lat_cfg cycles
  logic [0:15][31:0] s_blk = '0;
  logic [255:0] s_h = '0;
  logic s_valid = 1'b0, s_pv = 1'b0;
  int s_lag = 0, s_busy = 0, lat_cfg = 0;
  logic [31:0] slave_rd;
  always_comb begin
    slave_rd = 32'h0;
    if (bus.cs && !bus.we) begin
      if (bus.address == ADDR_STATUS)
        slave_rd = s_lag > 0 ? {30'h0, s_pv, 1'b1} : {30'h0, s_busy == 0 && s_valid, s_busy == 0};
      else if (bus.address[7:3] == 5'b00100)
        slave_rd = s_h[255 - 32*int'(bus.address[2:0]) -: 32];
    end
  end
  assign bus.read_data = slave_rd;
  always @(posedge clk) begin
    if (s_lag > 0) s_lag <= s_lag - 1;
    else if (s_busy > 0) s_busy <= s_busy - 1;
    if (bus.cs && bus.we) begin
      if (bus.address[7:4] == 4'h1) s_blk[bus.address[3:0]] <= bus.write_data;
      else if (bus.address == ADDR_CTRL && (bus.write_data[CTRL_INIT] || bus.write_data[CTRL_NEXT])) begin
        s_h     <= compress(bus.write_data[CTRL_INIT] ? h0(bus.write_data[CTRL_MODE]) : s_h, s_blk);
        s_pv    <= s_valid;
        s_valid <= 1'b1;
        s_lag   <= 2;
        s_busy  <= lat_cfg;
      end
    end
  end
  logic [41:0] trace [$];
  int dv_cnt = 0, polls_to = 0, dvt_cnt = 0;
  always @(negedge clk) begin
    trace.push_back({bus.cs, bus.we, bus.address, bus.write_data});
    if (dv) dv_cnt <= dv_cnt + 1;
    if (dv_t) dvt_cnt <= dvt_cnt + 1;
    if (bus_to.cs && !bus_to.we && bus_to.address == ADDR_STATUS) polls_to <= polls_to + 1;
  end
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [255:0] ref_h = '0;
  task automatic run_req(input logic [511:0] blk, input logic im, input logic sm, input logic poke, input string tag);
    int b, d0, lat, j, n;
    logic [255:0] exp;
    exp = compress(im ? h0(sm) : ref_h, blk);
    ref_h = exp;
    lat = $urandom_range(0, 40);
    @(negedge clk);
    lat_cfg = lat; block_in = blk; init_mode = im; sha_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    b = trace.size();
    d0 = dv_cnt;
    block_in = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    init_mode = ~im; sha_mode = ~sm;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (dv_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_dv_pulses"}, dv_cnt - d0, 1);
    check({tag, "_digest"}, digest, exp);
    check({tag, "_ready"}, ready, 1'b1);
    check({tag, "_err"}, err, 1'b0);
    for (int i = 0; i < 16; i++)
      check({tag, "_wr_block"}, trace[b+i], {2'b11, ADDR_BLOCK0 + 8'(i), blk[511-32*i -: 32]});
    check({tag, "_wr_ctrl"}, trace[b+16], {2'b11, ADDR_CTRL, 29'h0, sm, ~im, im});
    j = b + 17;
    n = 0;
    while (j < trace.size() && !trace[j][41]) begin
      j++;
      n++;
    end
    check({tag, "_holdoff"}, n, 4);
    n = 0;
    while (j < trace.size() && trace[j][41:32] == {2'b10, ADDR_STATUS}) begin
      j++;
      n++;
    end
    check({tag, "_polls"}, n, lat <= 2 ? 1 : lat - 1);
    for (int k = 0; k < 8; k++)
      check({tag, "_rd_digest"}, trace[j+k][41:32], {2'b10, ADDR_DIGEST0 + 8'(k)});
    check({tag, "_done_cs"}, trace[j+8][41:40], 2'b00);
  endtask
  initial begin
    logic [511:0] blk;
    int b, n;
    start = 1'b0; start_to = 1'b0; init_mode = 1'b0; sha_mode = 1'b0; block_in = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_cs", bus.cs, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_addr", bus.address, 8'h00);
    check("rst_wdata", bus.write_data, 32'h0);
    check("rst_dv", dv, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_digest", digest, 256'h0);
    check("rst_to_ready", ready_t, 1'b1);
    reset_n = 1'b1;
    run_req(ABC, 1'b1, 1'b1, 1'b1, "abc256");
    check("abc256_const", digest, ABC256);
    run_req(ABC, 1'b1, 1'b0, 1'b0, "abc224");
    check("abc224_const", digest[255:32], ABC224);
    @(negedge clk);
    start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    b = polls_to;
    n = dvt_cnt;
    for (int i = 0; i < 300 && !err_t; i++) @(negedge clk);
    check("to_err", err_t, 1'b1);
    check("to_polls", polls_to - b, 16);
    check("to_dv", dvt_cnt - n, 0);
    check("to_ready", ready_t, 1'b1);
    check("to_cs", bus_to.cs, 1'b0);
    check("to_digest", digest_t, 256'h0);
    @(negedge clk);
    start_to = 1'b1;
    @(posedge clk); #1;
    start_to = 1'b0;
    check("to_err_clear", err_t, 1'b0);
    for (int i = 0; i < 300 && !err_t; i++) @(negedge clk);
    check("to_err_again", err_t, 1'b1);
    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 16; w++) blk[511-32*w -: 32] = $urandom();
      run_req(blk, r == 0 ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end
    @(negedge clk);
    block_in = ABC; init_mode = 1'b1; sha_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_word7_addr", bus.address, 8'h17);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", bus.cs, 1'b0);
    check("mid_rst_we", bus.we, 1'b0);
    check("mid_rst_ready", ready, 1'b1);
    check("mid_rst_digest", digest, 256'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_req(ABC, 1'b1, 1'b1, 1'b0, "abc_after_rst");
    check("abc_after_rst_const", digest, ABC256);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sha256_bus_master.md
Name: sha256_bus_master

Overview:
- Drives the register interface of the sha256 slave (cs/we/address/write_data/read_data) to hash one 512-bit block per request.
- Sequence per request: write 16 block words, write CTRL with init or next, poll STATUS, read 8 digest words.
- Presents the 256-bit result on a simple start/valid handshake to the mining controller.

Parameters:
- HOLDOFF, 4, idle cycles (cs=0) between the CTRL write and the first STATUS poll. Must be >=3 so the slave's lagging ready bit is not sampled stale.
- TIMEOUT, 1024, maximum POLL cycles before the request is aborted with an error.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; accepted only when ready=1
- init_mode  in  1  1 = write CTRL init (first block), 0 = write CTRL next (chained block)
- sha_mode  in  1  CTRL mode bit: 1 = SHA-256, 0 = SHA-224
- block_in  in  512  message block; [511:480] is word 0
- ready  out  1  high in IDLE
- digest_out  out  256  last digest; [255:224] is read from address 0x20
- digest_valid  out  1  one-cycle pulse when digest_out updates
- error  out  1  sticky timeout flag; cleared by the next accepted start
- cs  out  1  slave chip select
- we  out  1  slave write enable
- address  out  8  slave address
- write_data  out  32  slave write data
- read_data  in  32  slave read data, combinational from cs/address in the same cycle

Behaviour:
- Interface: clock clk; reset reset_n, asynchronous, active-low.
- All outputs are registered.
- Reset values: cs=0, we=0, address=0, write_data=0, digest_out=0, digest_valid=0, error=0, ready=1, state=IDLE.
- IDLE:
  - start=1 latches block_in, init_mode and sha_mode, clears error, and moves to WR_BLOCK.
  - start is ignored in every other state.
- WR_BLOCK: 16 consecutive cycles with cs=1, we=1, address=0x10+i and write_data=word i, for i=0..15, then WR_CTRL.
- WR_CTRL: one cycle with cs=1, we=1, address=0x08, write_data={29'h0, sha_mode, ~init_mode, init_mode}, then HOLDOFF.
- HOLDOFF: cs=0 for HOLDOFF cycles, counted down, then POLL.
- POLL:
  - Every cycle drives cs=1, we=0, address=0x09.
  - read_data is sampled at the clock edge ending that cycle.
  - read_data[1:0]==2'b11 (valid and ready) -> RD_DIGEST.
  - Otherwise the poll counter increments. Reaching TIMEOUT sets error=1, drives cs=0, returns to IDLE, and leaves digest_out unchanged with no digest_valid pulse.
- RD_DIGEST:
  - 8 cycles with cs=1, we=0, address=0x20+k, for k=0..7.
  - read_data is captured into digest_out[255-32k -: 32] via a shadow register.
  - digest_out updates atomically on completion.
  - Then DONE.
- DONE: one cycle with digest_valid=1 and cs=0, then IDLE (ready=1 on the following cycle).
- cs is deasserted in IDLE, HOLDOFF and DONE. we=0 whenever cs=0.
- Latency, start accepted at edge 0: first block write is in cycle 1, CTRL write in cycle 17, first poll in cycle 18+HOLDOFF.
- In SHA-224 mode all 8 words are still read; only [255:32] is meaningful.
- Reset mid-operation: everything returns to reset values immediately and the FSM goes to IDLE. The slave's partial state is not cleaned up; the next request must use init_mode=1.
- Counters: a 4-bit word index wraps only at state exit. The poll counter is $clog2(TIMEOUT+1) bits and saturates.

Decomposition:
- Shared package sha256_pkg holds:
  - address constants ADDR_CTRL=0x08, ADDR_STATUS=0x09, ADDR_BLOCK0=0x10, ADDR_DIGEST0=0x20;
  - CTRL bit indices INIT=0, NEXT=1, MODE=2;
  - STATUS bit indices READY=0, VALID=1;
  - the FSM state enum.
- The slave should import the same constants.
- No sub-module; a single FSM with a datapath is sufficient.

Test Plan:
- Reset: hold reset_n=0 -> ready=1, cs=0, digest_valid=0, error=0, digest_out=0.
- SHA-256 "abc" through the real slave:
  - Stimulus: block 61626380_00000000x14_00000018, init_mode=1, sha_mode=1.
  - Required: digest_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with a single digest_valid pulse.
- Bus trace check on the same run:
  - Exactly 16 writes to 0x10..0x1f in order.
  - Then a write of 0x00000005 to 0x08.
  - Then HOLDOFF cycles with cs=0, polls of 0x09, and reads of 0x20..0x27.
- SHA-224 "abc" (sha_mode=0):
  - CTRL write_data=0x00000001.
  - digest_out[255:32]=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
- Timeout: stub slave returns STATUS=0 with TIMEOUT=16 -> error=1 after 16 polls, no digest_valid, ready=1. A following start clears error.
- Robustness:
  - start pulsed while in WR_BLOCK is ignored; the trace is unchanged.
  - reset_n asserted during WR_BLOCK word 7 -> cs=0 immediately.
  - After release, a fresh "abc" request yields the correct digest.
